// File: rtl/reg_trace_buffer.sv
// Register-file write trace buffer: filtered capture into a FWFT FIFO with timestamps.
// Optional change filtering is enabled with `define TRACE_CHANGE_FILTER_EN.
module reg_trace_buffer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 16,
    parameter int MAX_CYCLES = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [(2**ADDR_W)-1:0]   watch_mask,
    input  logic                     capture_en,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WIN_W = $clog2(MAX_CYCLES + 1);
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [TS_W-1:0]   r_mem_ts   [DEPTH];

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [TS_W-1:0]   r_ts;
    logic [WIN_W-1:0]  r_win;
    logic              r_ovf;
    logic              r_done;

    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_valid;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_req   = wr_en && capture_en && watch_mask[wr_addr]
                     && (wr_addr != '0) && !r_done;
    assign w_pop   = w_valid && out_ready;

`ifdef TRACE_CHANGE_FILTER_EN
    logic [DATA_W-1:0] r_shadow [NREG];
    logic              w_changed;

    assign w_changed = (wr_data != r_shadow[wr_addr]);
    assign w_push    = w_req && w_changed;

    // Shadow tracks every architectural write, captured or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end
`else
    assign w_push = w_req;
`endif

    // A push into a full FIFO lands only if the head leaves on the same edge.
    assign w_wr = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_addr[r_wptr] <= wr_addr;
            r_mem_data[r_wptr] <= wr_data;
            r_mem_ts[r_wptr]   <= r_ts;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Timestamp and window both freeze once the capture window closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts   <= '0;
            r_win  <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_ts <= r_ts + TS_W'(1);
            if (r_win == WIN_W'(MAX_CYCLES - 1)) begin
                r_done <= 1'b1;
            end else begin
                r_win <= r_win + WIN_W'(1);
            end
        end
    end

    assign out_valid = w_valid;
    assign out_addr  = r_mem_addr[r_rptr];
    assign out_data  = r_mem_data[r_rptr];
    assign out_ts    = r_mem_ts[r_rptr];
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_trace_buffer.sv
// Directed bench for reg_trace_buffer: vector table plus multi-cycle sequences.
// Define TRACE_CHANGE_FILTER_EN to match a filtered RTL build.
module tb_reg_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] watch_mask = '0;
    logic        capture_en = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic [15:0] out_ts;
    logic [4:0]  count;
    logic        overflow;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    reg_trace_buffer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .watch_mask(watch_mask),
        .capture_en(capture_en), .out_ready(out_ready),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .out_ts(out_ts), .count(count), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] m;
        logic        cap;
        logic        rdy;
        int          e_cnt;
        logic        e_v;
        int          e_a;
        int          e_d;
        int          e_ts;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic we, logic [4:0] a, logic [31:0] d,
                                logic [31:0] m, logic cap, logic rdy,
                                int c, logic v, int ea, int ed, int et);
        vec_t r;
        r.we = we; r.a = a; r.d = d; r.m = m; r.cap = cap; r.rdy = rdy;
        r.e_cnt = c; r.e_v = v; r.e_a = ea; r.e_d = ed; r.e_ts = et;
        return r;
    endfunction

    task automatic drive(logic we, logic [4:0] a, logic [31:0] d,
                         logic [31:0] m, logic cap, logic rdy);
        wr_en = we; wr_addr = a; wr_data = d;
        watch_mask = m; capture_en = cap; out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int c, logic v, int a, int d, int t,
                       logic ovf, logic dn);
        logic bad;
        n_vec++;
        bad = (int'(count) != c) || (out_valid != v) ||
              (overflow != ovf) || (done != dn);
        if (v && out_valid)
            bad = bad || (int'(out_addr) != a) || (int'(out_data) != d) ||
                  (int'(out_ts) != t);
        if (bad) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d v=%0b a=%0d d=%0d ts=%0d ovf=%0b done=%0b; want cnt=%0d v=%0b a=%0d d=%0d ts=%0d ovf=%0b done=%0b",
                     nm, count, out_valid, out_addr, out_data, out_ts,
                     overflow, done, c, v, a, d, t, ovf, dn);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_state", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0, 0, 0,     32'h1C, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,     32'h1C, 1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0,     32'h1C, 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 2, 5,     32'h1C, 1, 1, 1, 1, 2, 5, 3);
        tbl[4]  = mk(1, 3, 7,     32'h1C, 1, 1, 1, 1, 3, 7, 4);
        tbl[5]  = mk(1, 5, 9,     32'h1C, 1, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1,     32'hFFFF_FFFF, 1, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 2, 32'h11, 32'h1C, 0, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 2, 32'h22, 32'h1C, 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 4, 32'hAA, 32'h1C, 1, 0, 1, 1, 4, 32'hAA, 9);
        tbl[10] = mk(0, 0, 0,     32'h1C, 1, 0, 1, 1, 4, 32'hAA, 9);
        tbl[11] = mk(0, 0, 0,     32'h1C, 1, 1, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].m,
                  tbl[i].cap, tbl[i].rdy);
            tick();
            chk($sformatf("table[%0d]", i), tbl[i].e_cnt, tbl[i].e_v,
                tbl[i].e_a, tbl[i].e_d, tbl[i].e_ts, 0, 0);
        end

        // Fill, full push+pop, drain, then overflow.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 4, 100 + i, 32'h10, 1, 0);
            tick();
        end
        chk("fill16", 16, 1, 4, 100, 0, 0, 0);
        drive(1, 4, 200, 32'h10, 1, 1);
        tick();
        chk("full_push_pop", 16, 1, 4, 101, 1, 0, 0);
        drive(0, 0, 0, 32'h10, 1, 1);
        repeat (15) tick();
        chk("new_entry_last", 1, 1, 4, 200, 16, 0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(1, 4, 300 + i, 32'h10, 1, 0);
            tick();
        end
        chk("refill16", 16, 1, 4, 200, 16, 0, 0);
        drive(1, 4, 315, 32'h10, 1, 0);
        tick();
        chk("overflow", 16, 1, 4, 200, 16, 1, 0);
        drive(0, 0, 0, 32'h10, 1, 1);
        repeat (11) tick();
        chk("drain_to5", 5, 1, 4, 310, 42, 1, 0);

        // Asynchronous reset between edges, then capture at ts 0.
        drive(0, 0, 0, 32'h10, 1, 0);
        #2 rst = 1'b1;
        #1 chk("async_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 4, 77, 32'h10, 1, 0);
        tick();
        chk("post_reset_ts0", 1, 1, 4, 77, 0, 0, 0);

        // Window expiry with pending entries draining afterwards.
        do_reset();
        for (int k = 1; k <= 102; k++) begin
            drive(1, 4, k, 32'h10, 1, (k <= 96) ? 1'b1 : 1'b0);
            tick();
            if (k == 50)  chk("win_k50", 1, 1, 4, 50, 49, 0, 0);
            if (k == 96)  chk("win_k96", 1, 1, 4, 96, 95, 0, 0);
            if (k == 99)  chk("win_k99", 4, 1, 4, 96, 95, 0, 0);
            if (k == 100) chk("win_done", 5, 1, 4, 96, 95, 0, 1);
            if (k == 102) chk("win_nopush", 5, 1, 4, 96, 95, 0, 1);
        end
        for (int j = 1; j <= 5; j++) begin
            drive(1, 4, 500 + j, 32'h10, 1, 1);
            tick();
            chk($sformatf("win_drain%0d", j), 5 - j, (j < 5), 4,
                96 + j, 95 + j, 0, 1);
        end

        // Change filter: r2=5, r2=5, r2=6.
        do_reset();
        drive(1, 2, 5, 32'h04, 1, 0);
        tick();
        drive(1, 2, 5, 32'h04, 1, 0);
        tick();
        drive(1, 2, 6, 32'h04, 1, 0);
        tick();
`ifdef TRACE_CHANGE_FILTER_EN
        chk("filter_cnt", 2, 1, 2, 5, 0, 0, 0);
        drive(0, 0, 0, 32'h04, 1, 1);
        tick();
        chk("filter_next", 1, 1, 2, 6, 2, 0, 0);
`else
        chk("nofilter_cnt", 3, 1, 2, 5, 0, 0, 0);
        drive(0, 0, 0, 32'h04, 1, 1);
        tick();
        chk("nofilter_next", 2, 1, 2, 5, 1, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
